// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for a small CPU: debounced buttons, slow or fast run
// rate, and an 8-bit PC breakpoint that halts before the matching instruction executes.
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RATE_DIV        = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        mode_fast,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [15:0] ce_count
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RW  = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  RATE_LAST = RW'(RATE_DIV - 1);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StBrk  = 2'b11
  } state_e;

  // Button index 0 is run, index 1 is step.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DBW-1:0] db_cnt_q [2];
  logic [1:0]     press;
  logic           run_press, step_press;

  assign btn_raw = {btn_step, btn_run};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the accepted level.
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press      = deb_q & ~deb_prev_q;
  assign run_press  = press[0];
  assign step_press = press[1];

  state_e         state_q;
  logic [RW-1:0]  rate_q;
  logic           bp_skip_q;
  logic [15:0]    ce_count_q;
  logic           candidate, match;

  // cpu_ce is decoded combinationally so a pc/breakpoint change acts in the same cycle.
  always_comb begin
    candidate = mode_fast || (rate_q == RATE_LAST);
    match     = bp_en && (pc == bp_addr) && !bp_skip_q;
    case (state_q)
      StStep:  cpu_ce = 1'b1;
      StRun:   cpu_ce = !run_press && candidate && !match;
      default: cpu_ce = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHalt;
      rate_q     <= '0;
      bp_skip_q  <= 1'b0;
      ce_count_q <= '0;
    end else begin
      if (cpu_ce) ce_count_q <= ce_count_q + 16'd1;
      case (state_q)
        StHalt, StBrk: begin
          rate_q <= '0;
          if (run_press) begin
            state_q   <= StRun;
            bp_skip_q <= 1'b1;
          end else if (step_press) begin
            state_q <= StStep;
          end
        end
        StStep: begin
          rate_q  <= '0;
          state_q <= StHalt;
        end
        StRun: begin
          if (run_press) begin
            state_q <= StHalt;
            rate_q  <= '0;
          end else if (candidate && match) begin
            state_q <= StBrk;
            rate_q  <= '0;
          end else begin
            if (cpu_ce) bp_skip_q <= 1'b0;
            rate_q <= (mode_fast || candidate) ? '0 : rate_q + 1'b1;
          end
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  assign state    = state_q;
  assign bp_hit   = (state_q == StBrk);
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with short debounce and rate settings; expected pulses are queued
// as stimulus is applied and matched against each observed cpu_ce pulse.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic        mode_fast = 1'b0;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = 8'h00;
  logic [7:0]  pc;
  logic        pc_clr = 1'b1;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] ce_count;
  logic [15:0] model_cnt;

  int n_checks = 0;
  int n_pass = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RATE_DIV(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .mode_fast(mode_fast),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .pc(pc),
    .cpu_ce(cpu_ce),
    .state(state),
    .bp_hit(bp_hit),
    .ce_count(ce_count)
  );

  // Toy CPU: pc advances once per enabled cycle.
  always @(posedge clk) begin
    if (pc_clr) pc <= 8'h00;
    else if (cpu_ce) pc <= pc + 8'h01;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) model_cnt <= 16'h0000;
    else if (cpu_ce) model_cnt <= model_cnt + 16'h0001;
  end

  task automatic test_reset();
    rst = 1'b1;
    pc_clr = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (state !== 2'b00) $display("FAIL reset_state got %b want 00", state);
    else n_pass++;
    n_checks++; if (cpu_ce !== 1'b0) $display("FAIL reset_ce got %b want 0", cpu_ce);
    else n_pass++;
    n_checks++; if (bp_hit !== 1'b0) $display("FAIL reset_bp_hit got %b want 0", bp_hit);
    else n_pass++;
    n_checks++; if (ce_count !== 16'h0000) $display("FAIL reset_count got %h want 0000", ce_count);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    pc_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int bad_state = 0;
    for (int i = 0; i < 25; i++) begin
      btn_step = (i < 3);
      @(negedge clk);
      if (cpu_ce === 1'b1) pulses++;
      if (state !== 2'b00) bad_state++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL glitch_pulses got %0d want 0", pulses);
    else n_pass++;
    n_checks++; if (bad_state !== 0) $display("FAIL glitch_state got %0d non-halt cycles want 0", bad_state);
    else n_pass++;
  endtask

  task automatic test_step();
    exp_q.delete();
    exp_q.push_back(2);
    for (int i = 0; i < 30; i++) begin
      btn_step = (i < 10);
      @(negedge clk);
      if (cpu_ce === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL step_extra_pulse got pulse want none");
        else begin
          int e = exp_q.pop_front();
          if (state !== 2'(e)) $display("FAIL step_pulse_state got %b want %0d", state, e);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL step_missed got %0d pending want 0", exp_q.size());
    else n_pass++;
    n_checks++; if (state !== 2'b00) $display("FAIL step_final_state got %b want 00", state);
    else n_pass++;
    n_checks++; if (ce_count !== 16'h0001) $display("FAIL step_count got %h want 0001", ce_count);
    else n_pass++;
  endtask

  task automatic test_slow_run();
    int run_start = -1;
    mode_fast = 1'b0;
    bp_en = 1'b0;
    exp_q.delete();
    // Second press at i=30 suppresses the k=30 candidate; pulses at k=3..27 only.
    for (int k = 3; k < 30; k += 3) exp_q.push_back(k);
    for (int i = 0; i < 60; i++) begin
      btn_run = (i < 10) || (i >= 30 && i < 40);
      @(negedge clk);
      if (run_start < 0 && state === 2'b01) run_start = i;
      if (cpu_ce === 1'b1) begin
        n_checks++;
        if (run_start < 0 || exp_q.size() == 0)
          $display("FAIL slow_extra_pulse got pulse at cycle %0d want none", i);
        else begin
          int e = exp_q.pop_front();
          if (i - run_start + 1 !== e)
            $display("FAIL slow_pulse_pos got run cycle %0d want %0d", i - run_start + 1, e);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL slow_missed got %0d pending want 0", exp_q.size());
    else n_pass++;
    n_checks++; if (state !== 2'b00) $display("FAIL slow_final_state got %b want 00", state);
    else n_pass++;
    n_checks++; if (ce_count !== model_cnt) $display("FAIL slow_count got %h want %h", ce_count, model_cnt);
    else n_pass++;
  endtask

  task automatic test_breakpoint();
    mode_fast = 1'b1;
    bp_en = 1'b1;
    bp_addr = 8'h05;
    pc_clr = 1'b1;
    @(negedge clk);
    pc_clr = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 5; p++) exp_q.push_back(p);
    for (int i = 0; i < 40; i++) begin
      btn_run = (i < 10);
      @(negedge clk);
      if (cpu_ce === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra_pulse got pc %h want none", pc);
        else begin
          int e = exp_q.pop_front();
          if (pc !== 8'(e)) $display("FAIL bp_pulse_pc got %h want %h", pc, 8'(e));
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_missed got %0d pending want 0", exp_q.size());
    else n_pass++;
    n_checks++; if (state !== 2'b11) $display("FAIL bp_state got %b want 11", state);
    else n_pass++;
    n_checks++; if (bp_hit !== 1'b1) $display("FAIL bp_hit got %b want 1", bp_hit);
    else n_pass++;
    n_checks++; if (pc !== 8'h05) $display("FAIL bp_pc got %h want 05", pc);
    else n_pass++;
    // Resume: pc 5 must execute, then run continues until the halt press at i=20.
    for (int p = 5; p < 24; p++) exp_q.push_back(p);
    for (int i = 0; i < 40; i++) begin
      btn_run = (i < 10) || (i >= 20 && i < 30);
      @(negedge clk);
      if (cpu_ce === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL resume_extra_pulse got pc %h want none", pc);
        else begin
          int e = exp_q.pop_front();
          if (pc !== 8'(e)) $display("FAIL resume_pulse_pc got %h want %h", pc, 8'(e));
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL resume_missed got %0d pending want 0", exp_q.size());
    else n_pass++;
    n_checks++; if (state !== 2'b00) $display("FAIL resume_state got %b want 00", state);
    else n_pass++;
    n_checks++; if (ce_count !== model_cnt) $display("FAIL bp_count got %h want %h", ce_count, model_cnt);
    else n_pass++;
    bp_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    int saw_step = 0;
    int saw_run = 0;
    mode_fast = 1'b1;
    for (int i = 0; i < 45; i++) begin
      btn_run = (i < 10) || (i >= 20 && i < 30);
      btn_step = (i < 10);
      @(negedge clk);
      if (state === 2'b10) saw_step++;
      if (state === 2'b01) saw_run++;
    end
    n_checks++; if (saw_step !== 0) $display("FAIL simul_step_visit got %0d want 0", saw_step);
    else n_pass++;
    n_checks++; if (saw_run == 0) $display("FAIL simul_run got 0 run cycles want >0");
    else n_pass++;
    n_checks++; if (state !== 2'b00) $display("FAIL simul_final_state got %b want 00", state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int reached = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode_fast = 1'b1;
    for (int i = 0; i < 100 && reached == 0; i++) begin
      btn_run = (i < 10);
      @(negedge clk);
      if (model_cnt == 16'h0010) reached = 1;
    end
    btn_run = 1'b0;
    n_checks++;
    if (reached == 0) $display("FAIL midrun_reach got %h want 0010", model_cnt);
    else if (ce_count !== 16'h0010) $display("FAIL midrun_count got %h want 0010", ce_count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (state !== 2'b00) $display("FAIL midrun_rst_state got %b want 00", state);
    else n_pass++;
    n_checks++; if (cpu_ce !== 1'b0) $display("FAIL midrun_rst_ce got %b want 0", cpu_ce);
    else n_pass++;
    n_checks++; if (ce_count !== 16'h0000) $display("FAIL midrun_rst_count got %h want 0000", ce_count);
    else n_pass++;
    // Step button held through reset release yields exactly one step.
    btn_step = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(2);
    for (int i = 0; i < 35; i++) begin
      btn_step = (i < 15);
      @(negedge clk);
      if (cpu_ce === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL held_extra_pulse got pulse want none");
        else begin
          int e = exp_q.pop_front();
          if (state !== 2'(e)) $display("FAIL held_pulse_state got %b want %0d", state, e);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL held_missed got %0d pending want 0", exp_q.size());
    else n_pass++;
    n_checks++; if (ce_count !== 16'h0001) $display("FAIL held_count got %h want 0001", ce_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_step();
    test_slow_run();
    test_breakpoint();
    test_simultaneous();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable samples required to accept a button level.
REQ-002 SHALL provide parameter RATE_DIV, default 50000000, clk cycles between CPU enable pulses in slow-run mode (legal range >= 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_run  input  1  raw asynchronous run/halt toggle button.
REQ-006 SHALL have port btn_step  input  1  raw asynchronous single-step button.
REQ-007 SHALL have port mode_fast  input  1  1 = enable CPU every cycle in RUN; 0 = one enable per RATE_DIV cycles.
REQ-008 SHALL have port bp_en  input  1  breakpoint enable.
REQ-009 SHALL have port bp_addr  input  8  breakpoint address.
REQ-010 SHALL have port pc  input  8  current CPU program counter.
REQ-011 SHALL have port cpu_ce  output  1  CPU clock enable, one instruction per high cycle.
REQ-012 SHALL have port state  output  2  FSM state: 00 HALT, 01 RUN, 10 STEP, 11 BRK.
REQ-013 SHALL have port bp_hit  output  1  high while state == BRK.
REQ-014 SHALL have port ce_count  output  16  count of cpu_ce pulses since reset.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after DEBOUNCE_CYCLES consecutive cycles of an unchanged synchronized value; any change restarts the count.
REQ-016 A 0->1 transition of a debounced level SHALL produce exactly one single-cycle press pulse; release SHALL produce none.
REQ-017 HALT: cpu_ce = 0; run press -> RUN; step press -> STEP.
REQ-018 STEP: cpu_ce = 1 for exactly that one cycle, then unconditionally -> HALT; all presses ignored.
REQ-019 RUN: candidate enable = 1 every cycle when mode_fast = 1; otherwise = 1 only when rate counter == RATE_DIV-1.
REQ-020 Rate counter SHALL count 0..RATE_DIV-1 and wrap to 0; it SHALL be held at 0 outside RUN and while mode_fast = 1, so the first slow enable occurs RATE_DIV cycles after entering RUN.
REQ-021 Breakpoint match = bp_en && (pc == bp_addr) && !bp_skip.
REQ-022 In RUN, cpu_ce = candidate && !match; a candidate cycle with match SHALL assert no cpu_ce and transition -> BRK (halt before executing bp_addr).
REQ-023 bp_skip SHALL be set on every entry to RUN and cleared on the first cpu_ce pulse in RUN, so resuming at a breakpoint address executes it once.
REQ-024 In RUN, run press -> HALT with cpu_ce = 0 that cycle; run press takes priority over breakpoint match; step press ignored.
REQ-025 BRK: cpu_ce = 0; run press -> RUN; step press -> STEP (step ignores breakpoint).
REQ-026 Simultaneous run and step press in HALT or BRK SHALL select RUN; step discarded.
REQ-027 ce_count SHALL increment by 1 on every cpu_ce = 1 cycle, wrapping 0xFFFF -> 0x0000.
REQ-028 Mid-run changes of mode_fast, bp_en or bp_addr SHALL take effect the same cycle without leaving RUN.

Reset
REQ-029 rst SHALL asynchronously force state = HALT, cpu_ce = 0, bp_hit = 0, ce_count = 0, rate counter = 0, bp_skip = 0, synchronizers, debounced levels and debounce counters = 0.
REQ-030 A button held through reset release SHALL produce one press pulse after DEBOUNCE_CYCLES plus synchronizer latency.
REQ-031 rst asserted in any state SHALL abort it; no cpu_ce pulse follows until a new press.

Verification (DEBOUNCE_CYCLES=4, RATE_DIV=3)
REQ-032 Glitch btn_step high 3 cycles then low -> no press, state stays 00, cpu_ce never 1.
REQ-033 From HALT, btn_step held 10 cycles -> exactly one cpu_ce pulse, state 00->10->00, ce_count = 1.
REQ-034 Run press, mode_fast = 0, bp_en = 0 -> cpu_ce pulses every 3rd cycle, first on the 3rd cycle in RUN; second run press -> state 00, pulses stop.
REQ-035 mode_fast = 1, bp_en = 1, bp_addr = 0x05, pc advancing 0,1,2,... per cpu_ce -> pulses for pc 0..4, no pulse at pc 5, state 11, bp_hit = 1; run press -> pc 5 executes, continues.
REQ-036 Run and step pressed in the same cycle from HALT -> state 01, no STEP visit.
REQ-037 rst asserted mid-RUN with ce_count = 0x0010 -> state 00, cpu_ce = 0, ce_count = 0 immediately, independent of clk.
